// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg
//   Shared constants and helpers for the 4x4 key-matrix scanner.
//   - KS_REG_*      : register offsets decoded on addr[1:0]
//   - KS_EVT_*      : bit positions of the fields in the event register
//   - KS_FIFO_DEPTH : number of entries in the press-code FIFO
//   - ks_lowest_row : picks the lowest set row of a 4-bit drain mask
package keypad_scan_pkg;

  localparam logic [1:0] KS_REG_STATE = 2'd0;
  localparam logic [1:0] KS_REG_EVT   = 2'd1;
  localparam logic [1:0] KS_REG_PEND  = 2'd2;
  localparam logic [1:0] KS_REG_NONE  = 2'd3;

  localparam int KS_EVT_HEAD_LSB     = 0;
  localparam int KS_EVT_NONEMPTY_BIT = 4;
  localparam int KS_EVT_COUNT_LSB    = 5;
  localparam int KS_EVT_OVF_BIT      = 8;

  localparam int KS_FIFO_DEPTH = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] row;
  } ks_pick_t;

  // Lowest-row-first selection: iterate high to low so the last hit wins.
  function automatic ks_pick_t ks_lowest_row(input logic [3:0] mask);
    ks_pick_t p;
    p = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) begin
        p.valid = 1'b1;
        p.row   = 2'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/keypad_scan_key_fifo.sv
// key_fifo
//   Synchronous 4-entry x 4-bit FIFO holding key press codes.
//   Ports:
//     clk, reset_n   : clock, asynchronous active-low reset
//     push, push_code: write request and the code to store
//     pop            : read request (ignored while empty)
//     head           : oldest entry, 0 when empty
//     count          : number of stored entries (0..4)
//     full, empty    : occupancy flags
//   A push while full is accepted only if a pop happens in the same cycle;
//   otherwise it is dropped (the caller records the overflow).
module key_fifo
  import keypad_scan_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [3:0] push_code,
  input  logic       pop,
  output logic [3:0] head,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  logic [3:0] mem [KS_FIFO_DEPTH];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic       do_pop;
  logic       do_push;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'(KS_FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? 4'd0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < KS_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
//   Memory-mapped 4x4 key-matrix scanner. Drives one active-low column at a
//   time, synchronises and debounces the active-low rows, keeps a live key
//   bitmap, and queues press events into a code FIFO plus a sticky mask.
//   Ports:
//     clk, reset_n          : clock, asynchronous active-low reset
//     strobe, rw, addr, d_in: bus access (rw=1 write), addr[1:0] decoded
//     d_out                 : combinational read data
//     col                   : active-low one-cold column drive
//     row                   : raw active-low row sense (asynchronous)
//   Registers: 0 key state, 1 event (head/nonempty/count/overflow, read
//   pops, write bit 8 clears overflow), 2 pending (write-1-to-clear), 3 zero.
//   Bus handshake: a transfer is a single cycle in which strobe is high; there
//   is no wait state, reads return data in that same cycle.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int CNT_BITS  = 16,
  parameter int DEB_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic [3:0]  col,
  input  logic [3:0]  row
);

  localparam int CW = CNT_BITS + 2;

  // ---------------- scan counter and column drive ----------------
  logic [CW-1:0] counter;
  logic [1:0]    cur_c;
  logic          sample_pt;

  assign cur_c     = counter[CNT_BITS +: 2];
  assign sample_pt = &counter[CNT_BITS-1:0];

  // col is registered from the counter, so it lags a column roll by a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
      col     <= 4'b1110;
    end else begin
      counter <= counter + CW'(1);
      col     <= ~(4'b0001 << cur_c);
    end
  end

  // ---------------- row synchroniser ----------------
  logic [3:0] row_m;
  logic [3:0] row_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_m <= 4'b1111;
      row_s <= 4'b1111;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // ---------------- debounce array ----------------
  // state_a[c][r] is key c*4+r, so the packed vector is the key bitmap.
  logic [3:0][3:0] state_a;
  logic [2:0]      deb_cnt [4][4];
  logic [3:0]      smp;
  logic [3:0]      flip;
  logic [3:0]      press;
  logic [2:0]      cnt_nxt [4];

  always_comb begin
    smp   = ~row_s;
    flip  = '0;
    press = '0;
    for (int r = 0; r < 4; r++) begin
      cnt_nxt[r] = '0;
      if (smp[r] != state_a[cur_c][r]) begin
        if (deb_cnt[cur_c][r] + 3'd1 == 3'(DEB_SCANS)) begin
          flip[r]  = 1'b1;
          press[r] = smp[r];
        end else begin
          cnt_nxt[r] = deb_cnt[cur_c][r] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_a <= '0;
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) deb_cnt[c][r] <= '0;
      end
    end else if (sample_pt) begin
      for (int r = 0; r < 4; r++) begin
        deb_cnt[cur_c][r] <= cnt_nxt[r];
        if (flip[r]) state_a[cur_c][r] <= smp[r];
      end
    end
  end

  // ---------------- press drain ----------------
  // The mask is empty again long before the next sample point (a column
  // dwell is at least 8 cycles), so loading it never loses events.
  logic [3:0] drain_mask;
  logic [1:0] drain_c;
  ks_pick_t   pick;
  logic       push;
  logic [3:0] push_code;

  assign pick      = ks_lowest_row(drain_mask);
  assign push      = pick.valid;
  assign push_code = {drain_c, pick.row};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drain_mask <= '0;
      drain_c    <= '0;
    end else if (sample_pt) begin
      drain_mask <= press;
      drain_c    <= cur_c;
    end else if (pick.valid) begin
      drain_mask[pick.row] <= 1'b0;
    end
  end

  // ---------------- event FIFO ----------------
  logic [1:0] reg_sel;
  logic       fifo_pop;
  logic [3:0] head;
  logic [2:0] count;
  logic       full;
  logic       empty;

  assign reg_sel  = addr[1:0];
  assign fifo_pop = strobe & ~rw & (reg_sel == KS_REG_EVT);

  key_fifo u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_code(push_code),
    .pop      (fifo_pop),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // ---------------- overflow and pending ----------------
  logic        ovf;
  logic        ovf_set;
  logic        ovf_clr;
  logic [15:0] pending;
  logic [15:0] pend_set;
  logic [15:0] pend_clr;

  // A pop in the same cycle makes room, so only an unpaired push overflows.
  assign ovf_set  = push & full & ~fifo_pop;
  assign ovf_clr  = strobe & rw & (reg_sel == KS_REG_EVT) & d_in[KS_EVT_OVF_BIT];
  assign pend_set = push ? (16'd1 << push_code) : 16'd0;
  assign pend_clr = (strobe & rw & (reg_sel == KS_REG_PEND)) ? d_in[15:0] : 16'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf     <= 1'b0;
      pending <= '0;
    end else begin
      ovf     <= (ovf & ~ovf_clr) | ovf_set;
      pending <= (pending & ~pend_clr) | pend_set;
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    d_out = '0;
    case (reg_sel)
      KS_REG_STATE: d_out[15:0] = state_a;
      KS_REG_EVT: begin
        d_out[KS_EVT_HEAD_LSB +: 4]  = head;
        d_out[KS_EVT_NONEMPTY_BIT]   = ~empty;
        d_out[KS_EVT_COUNT_LSB +: 3] = count;
        d_out[KS_EVT_OVF_BIT]        = ovf;
      end
      KS_REG_PEND:  d_out[15:0] = pending;
      default:      d_out = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, addr[31:2], d_in[31:16]};

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
//   Randomised and directed stimulus for keypad_scan with CNT_BITS=3,
//   DEB_SCANS=2. A key-matrix model drives row from col and a key bitmap.
//   A reference model steps once per clock at the level of scan samples,
//   run-lengths of disagreeing samples and a queue of FIFO contents; a
//   monitor compares every bus read and col against it.
module tb_keypad_scan;

  localparam int CNT_BITS  = 3;
  localparam int DEB_SCANS = 2;
  localparam int DWELL     = 1 << CNT_BITS;
  localparam int SCAN      = 4 * DWELL;

  // ---------------- clock / reset / DUT ----------------
  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        strobe  = 1'b0;
  logic        rw      = 1'b0;
  logic [31:0] addr    = '0;
  logic [31:0] d_in    = '0;
  logic [31:0] d_out;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys    = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scan #(.CNT_BITS(CNT_BITS), .DEB_SCANS(DEB_SCANS)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (strobe),
    .rw     (rw),
    .addr   (addr),
    .d_in   (d_in),
    .d_out  (d_out),
    .col    (col),
    .row    (row)
  );

  // Physical matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  int          cnt_m = 0;
  int          col_c = 0;
  logic [15:0] m_state = '0;
  logic [15:0] m_pend  = '0;
  logic        m_ovf   = 1'b0;
  int          m_run [16];
  logic [3:0]  exp_q [$];
  logic [3:0]  drain_q [$];

  task automatic model_clear();
    cnt_m   = 0;
    col_c   = 0;
    m_state = '0;
    m_pend  = '0;
    m_ovf   = 1'b0;
    exp_q.delete();
    drain_q.delete();
    for (int k = 0; k < 16; k++) m_run[k] = 0;
  endtask

  // Applies the effects of the clock cycle that ends at this posedge.
  task automatic model_step();
    logic [15:0] pset, pclr;
    logic        oset, oclr;
    logic [3:0]  code;
    int          c, k;
    pset = '0; pclr = '0; oset = 1'b0; oclr = 1'b0;
    if (strobe && rw && addr[1:0] == 2'd1 && d_in[8]) oclr = 1'b1;
    if (strobe && rw && addr[1:0] == 2'd2) pclr = d_in[15:0];
    // one queued press event per cycle after its sample
    if (drain_q.size() > 0) begin
      code = drain_q.pop_front();
      pset[code] = 1'b1;
      if (exp_q.size() < 4) exp_q.push_back(code);
      else oset = 1'b1;
    end
    m_ovf  = (m_ovf & ~oclr) | oset;
    m_pend = (m_pend & ~pclr) | pset;
    if (cnt_m % DWELL == DWELL - 1) begin
      c = (cnt_m / DWELL) % 4;
      for (int r = 0; r < 4; r++) begin
        k = c * 4 + r;
        if (keys[k] == m_state[k]) m_run[k] = 0;
        else begin
          m_run[k]++;
          if (m_run[k] == DEB_SCANS) begin
            m_state[k] = keys[k];
            m_run[k]   = 0;
            if (keys[k]) drain_q.push_back(4'(k));
          end
        end
      end
    end
    col_c = (cnt_m / DWELL) % 4;
    cnt_m = (cnt_m + 1) % SCAN;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (!reset_n) model_clear();
      else model_step();
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    logic [3:0]  one;
    logic [3:0]  hd;
    logic [31:0] exp;
    one = 4'b0001;
    forever begin
      @(negedge clk);
      if (!reset_n) model_clear();
      check("col", {28'b0, col}, {28'b0, ~(one << col_c)});
      if (strobe && !rw) begin
        case (addr[1:0])
          2'd0: begin
            exp = {16'b0, m_state};
            check("rd_state", d_out, exp);
          end
          2'd1: begin
            hd  = (exp_q.size() != 0) ? exp_q[0] : 4'h0;
            exp = {23'b0, m_ovf, 3'(exp_q.size()), (exp_q.size() != 0), hd};
            check("rd_evt", d_out, exp);
            if (reset_n && exp_q.size() > 0) void'(exp_q.pop_front());
          end
          2'd2: begin
            exp = {16'b0, m_pend};
            check("rd_pend", d_out, exp);
          end
          default: begin
            exp = '0;
            check("rd_rsvd", d_out, exp);
          end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (cnt_m != target && n < 2 * SCAN);
    if (cnt_m != target) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: counter %0d expected %0d", cnt_m, target);
    end
  endtask

  // Keys only change at the start of a column dwell, well clear of a sample.
  task automatic set_keys(input logic [15:0] v);
    int n;
    n = 0;
    while (cnt_m % DWELL != 0 && n < 2 * DWELL) begin
      tick();
      n++;
    end
    keys = v;
  endtask

  task automatic bus_read(input logic [1:0] a);
    strobe = 1'b1;
    rw     = 1'b0;
    addr   = {30'b0, a};
    tick();
    strobe = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
    strobe = 1'b1;
    rw     = 1'b1;
    addr   = {30'b0, a};
    d_in   = data;
    tick();
    strobe = 1'b0;
    rw     = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rnd_keys;
    int          n_ops;
    int          op;

    // reset state, read while held and after release
    idle(2);
    bus_read(2'd0);
    bus_read(2'd1);
    bus_read(2'd2);
    reset_n = 1'b1;
    bus_read(2'd0);
    bus_read(2'd1);
    bus_read(2'd2);
    bus_read(2'd3);

    // single key 6
    set_keys(16'h0040);
    idle(3 * SCAN);
    bus_read(2'd0);
    bus_read(2'd1);
    bus_read(2'd1);
    bus_read(2'd2);
    bus_write(2'd2, 32'h0000_FFFF);
    bus_read(2'd2);
    set_keys(16'h0000);
    idle(3 * SCAN);
    bus_read(2'd0);

    // bounce: key 6 toggles every scan, never two equal samples in a row
    for (int i = 0; i < 8; i++) begin
      wait_cnt(DWELL);
      keys[6] = ~keys[6];
    end
    set_keys(16'h0000);
    bus_read(2'd0);
    bus_read(2'd1);
    bus_read(2'd2);
    idle(3 * SCAN);

    // same-column burst: keys 0, 1, 3; watch pending cycle by cycle
    wait_cnt(0);
    keys = 16'h000B;
    wait_cnt(0);
    wait_cnt(6);
    repeat (6) bus_read(2'd2);
    repeat (4) bus_read(2'd1);
    set_keys(16'h0000);
    idle(3 * SCAN);
    bus_write(2'd2, 32'h0000_FFFF);

    // overflow with five presses, then clear
    wait_cnt(0);
    keys = 16'h001F;
    idle(3 * SCAN);
    bus_read(2'd0);
    bus_read(2'd2);
    bus_read(2'd1);
    bus_write(2'd1, 32'h0000_0100);
    repeat (4) bus_read(2'd1);
    set_keys(16'h0000);
    idle(3 * SCAN);
    bus_write(2'd2, 32'h0000_FFFF);

    // pop on a full FIFO in the cycle key 4 is pushed
    wait_cnt(0);
    keys = 16'h001F;
    wait_cnt(0);
    wait_cnt(2 * DWELL);
    bus_read(2'd1);
    bus_read(2'd1);
    repeat (5) bus_read(2'd1);
    set_keys(16'h0000);
    idle(3 * SCAN);
    bus_write(2'd2, 32'h0000_FFFF);

    // pending clear colliding with the key-6 set
    wait_cnt(0);
    keys = 16'h0040;
    wait_cnt(2 * DWELL);
    wait_cnt(2 * DWELL);
    bus_write(2'd2, 32'h0000_0040);
    bus_read(2'd2);
    bus_read(2'd1);
    bus_write(2'd2, 32'h0000_0040);
    bus_read(2'd2);
    set_keys(16'h0000);
    idle(3 * SCAN);

    // reset in the middle of a drain
    wait_cnt(0);
    keys = 16'h000F;
    wait_cnt(0);
    wait_cnt(DWELL + 1);
    reset_n = 1'b0;
    bus_read(2'd0);
    bus_read(2'd1);
    bus_read(2'd2);
    keys = 16'h0000;
    idle(2);
    reset_n = 1'b1;
    idle(2);
    bus_read(2'd0);
    bus_read(2'd1);
    bus_read(2'd2);

    // randomised keys and bus traffic
    for (int it = 0; it < 25; it++) begin
      rnd_keys = 16'($urandom) & 16'($urandom) & 16'($urandom);
      set_keys(rnd_keys);
      n_ops = $urandom_range(30, 90);
      repeat (n_ops) begin
        op = $urandom_range(0, 7);
        case (op)
          0, 1: bus_read(2'($urandom_range(0, 3)));
          2:    bus_read(2'd1);
          3:    bus_write(2'd1, $urandom);
          4:    bus_write(2'd2, $urandom);
          5:    bus_write(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, $urandom);
          default: tick();
        endcase
      end
    end
    set_keys(16'h0000);
    idle(3 * SCAN);
    bus_read(2'd0);
    repeat (5) bus_read(2'd1);
    bus_read(2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
